sub_multiword_seq: RTL and testbench

Multi-precision subtract sequencer. It accepts a WORDS×32-bit operand pair over a valid/ready handshake and computes a − b − borrow_in by walking the operands through a single shared `subtractor32bit` instance, one 32-bit word per cycle, least-significant word first, with the borrow registered between words. It sits between the ALU operand registers and the result bus, so the 64/128-bit subtract ops reuse the same 32-bit subtractor datapath instead of a wider one.

---
 rtl/sub_multiword_seq.sv | 192 +++++++++++++++++++
 tb/tb_sub_multiword_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_multiword_seq.sv
// sub_multiword_seq -- multi-precision subtract sequencer.
//
// Computes diff = op_a - op_b - borrow_in over WORDS 32-bit words by stepping
// one word per cycle (least-significant first) through a single shared
// 32-bit subtractor, with the borrow carried in a register between words.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (accepted only in IDLE)
//   op_a, op_b, borrow_in   minuend, subtrahend, initial borrow
//   out_valid / out_ready   result handshake (held in DONE until taken)
//   diff                    op_a - op_b - borrow_in mod 2^(32*WORDS)
//   borrow_out              1 iff op_a < op_b + borrow_in (unsigned)
//   zero                    diff == 0
//   ovf                     signed overflow of the full-width subtract
//   busy                    high while words are being processed

// 32-bit subtract with borrow in/out; the only arithmetic subtractor used.
module subtractor32bit (
  input  logic [31:0] subtractor_in0,
  input  logic [31:0] subtractor_in1,
  input  logic        borrow_in,
  output logic [31:0] subtractor_out,
  output logic        borrow_out
);
  logic [32:0] full;

  // A negative result shows up as bit 32 set in the 33-bit difference.
  assign full           = {1'b0, subtractor_in0} - {1'b0, subtractor_in1} - {32'd0, borrow_in};
  assign subtractor_out = full[31:0];
  assign borrow_out     = full[32];
endmodule

module sub_multiword_seq #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  borrow_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   diff,
  output logic                  borrow_out,
  output logic                  zero,
  output logic                  ovf,
  output logic                  busy
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MSB   = 32*WORDS - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 borrow_q, borrow_d;
  logic [32*WORDS-1:0]  a_q, a_d;
  logic [32*WORDS-1:0]  b_q, b_d;
  logic                 zacc_q, zacc_d;       // all words so far were zero
  logic                 borrow_out_q, borrow_out_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;

  logic [31:0]          a_w [WORDS];
  logic [31:0]          b_w [WORDS];
  logic [31:0]          sub_out;
  logic                 sub_bout;
  logic                 capture;
  logic                 step;
  logic                 last;
  logic                 word_zero;

  assign capture   = (state_q == IDLE) && in_valid;
  assign step      = (state_q == RUN);
  assign last      = (idx_q == LAST_IDX);
  assign word_zero = (sub_out == 32'd0);

  // Word views of the captured operands, and per-word result registers.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_q;

      assign a_w[gi] = a_q[gi*32 +: 32];
      assign b_w[gi] = b_q[gi*32 +: 32];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q <= 32'd0;
        end else if (step && (idx_q == IDX_W'(gi))) begin
          word_q <= sub_out;
        end
      end

      assign diff[gi*32 +: 32] = word_q;
    end
  endgenerate

  subtractor32bit u_sub (
    .subtractor_in0 (a_w[idx_q]),
    .subtractor_in1 (b_w[idx_q]),
    .borrow_in      (borrow_q),
    .subtractor_out (sub_out),
    .borrow_out     (sub_bout)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q == RUN);
    out_valid = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    zacc_d       = zacc_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    if (capture) begin
      a_d      = op_a;
      b_d      = op_b;
      borrow_d = borrow_in;
      idx_d    = '0;
      zacc_d   = 1'b1;
    end else if (step) begin
      borrow_d = sub_bout;
      zacc_d   = zacc_q & word_zero;
      if (last) begin
        // Flags land together with the top word; sub_out is that word.
        borrow_out_d = sub_bout;
        zero_d       = zacc_q & word_zero;
        ovf_d        = (a_q[MSB] != b_q[MSB]) && (sub_out[31] != a_q[MSB]);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      zacc_q       <= 1'b0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      zacc_q       <= zacc_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
    end
  end

  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_sub_multiword_seq.sv
module tb_sub_multiword_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WORDS=2 instance (directed tests)
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
  logic [63:0] op_a2 = '0, op_b2 = '0, diff2;
  logic        bin2 = 1'b0, bout2, zero2, ovf2, busy2;

  // WORDS=4 instance (random scoreboard test)
  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [127:0] op_a4 = '0, op_b4 = '0, diff4;
  logic         bin4 = 1'b0, bout4, zero4, ovf4, busy4;

  sub_multiword_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a2), .op_b(op_b2), .borrow_in(bin2), .out_valid(out_valid2),
    .out_ready(out_ready2), .diff(diff2), .borrow_out(bout2), .zero(zero2),
    .ovf(ovf2), .busy(busy2)
  );

  sub_multiword_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .borrow_in(bin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .diff(diff4), .borrow_out(bout4), .zero(zero4),
    .ovf(ovf4), .busy(busy4)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [127:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[7];
  exp_t sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Runs one WORDS=2 operation; entered and left at posedge+1 with dut2 in IDLE.
  task automatic run2(input vec_t v, input string tag);
    int lat;
    int nbusy;
    op_a2 = v.a; op_b2 = v.b; bin2 = v.bin; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0; nbusy = 0;
    while (!out_valid2 && lat < 20) begin
      if (busy2) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(2));
    check({tag, "_busy_cycles"}, 128'(nbusy), 128'(2));
    check({tag, "_diff"}, 128'(diff2), 128'(v.diff));
    check({tag, "_borrow_out"}, 128'(bout2), 128'(v.bout));
    check({tag, "_zero"}, 128'(zero2), 128'(v.zero));
    check({tag, "_ovf"}, 128'(ovf2), 128'(v.ovf));
    check({tag, "_in_ready_done"}, 128'(in_ready2), 128'(0));
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check({tag, "_back_to_idle"}, 128'({in_ready2, out_valid2}), 128'(2'b10));
    $display("op %s a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d zero=%0d ovf=%0d",
             tag, v.a, v.b, v.bin, diff2, bout2, zero2, ovf2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   cnt;
    vecs[0] = '{64'd10, 64'd5, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{64'd20, 64'd5, 1'b1, 64'd14, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 128'(in_ready2), 128'(1));
    check("reset_out_valid", 128'(out_valid2), 128'(0));
    check("reset_busy", 128'(busy2), 128'(0));
    check("reset_diff", 128'(diff2), 128'(0));
    check("reset_flags", 128'({bout2, zero2, ovf2}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 128'(in_ready2), 128'(1));

    // Table-driven directed vectors
    for (int i = 0; i < 7; i++) run2(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold DONE for 5 cycles with in_valid pulses ignored
    op_a2 = 64'd100; op_b2 = 64'd1; bin2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    cnt = 0;
    while (!out_valid2 && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("bp_reach_done", 128'(out_valid2), 128'(1));
    for (int i = 0; i < 5; i++) begin
      op_a2 = 64'd999; op_b2 = 64'd3; bin2 = 1'b1; in_valid2 = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", 128'(out_valid2), 128'(1));
      check("bp_in_ready", 128'(in_ready2), 128'(0));
      check("bp_diff", 128'(diff2), 128'(99));
      check("bp_flags", 128'({bout2, zero2, ovf2}), 128'(0));
      $display("stall cycle %0d out_valid=%0d diff=%0h", i, out_valid2, diff2);
    end
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    @(posedge clk); #1;
    out_ready2 = 1'b0;
    check("bp_release_idle", 128'({in_ready2, out_valid2}), 128'(2'b10));
    run2(vecs[3], "after_bp");

    // Reset during the first RUN cycle
    op_a2 = 64'd50; op_b2 = 64'd7; bin2 = 1'b0; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("rst_mid_busy_before", 128'(busy2), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", 128'(in_ready2), 128'(1));
    check("rst_mid_out_valid", 128'(out_valid2), 128'(0));
    check("rst_mid_busy", 128'(busy2), 128'(0));
    check("rst_mid_diff", 128'(diff2), 128'(0));
    check("rst_mid_flags", 128'({bout2, zero2, ovf2}), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_stale_valid", 128'(out_valid2), 128'(0));
    end
    v = '{64'd15, 64'd15, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
    run2(v, "post_reset");

    // Random WORDS=4 with scoreboard and random out_ready stalls
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic [128:0] full;
      logic [127:0] a, b;
      logic bin;
      exp_t e;
      exp_t p;
      while (got < 1000 && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        in_valid4 = 1'b0;
        out_ready4 = ($urandom_range(0, 3) != 0);
        if (out_valid4 && out_ready4) begin
          if (sb.size() == 0) begin
            check("rand_unexpected_output", 128'(1), 128'(0));
          end else begin
            p = sb.pop_front();
            check("rand_diff", diff4, p.diff);
            check("rand_borrow_out", 128'(bout4), 128'(p.bout));
            check("rand_zero", 128'(zero4), 128'(p.zero));
            check("rand_ovf", 128'(ovf4), 128'(p.ovf));
            $display("rand %0d diff=%0h bout=%0d zero=%0d ovf=%0d", got, diff4, bout4, zero4, ovf4);
          end
          got++;
        end
        if (in_ready4 && sent < 1000) begin
          a = {$urandom, $urandom, $urandom, $urandom};
          b = {$urandom, $urandom, $urandom, $urandom};
          if ($urandom_range(0, 15) == 0) b = a;
          if ($urandom_range(0, 15) == 0) a[127:32] = b[127:32];
          bin = 1'($urandom_range(0, 1));
          full = {1'b0, a} - {1'b0, b} - 129'(bin);
          e.diff = full[127:0];
          e.bout = full[128];
          e.zero = (full[127:0] == 128'd0);
          e.ovf  = (a[127] != b[127]) && (full[127] != a[127]);
          sb.push_back(e);
          op_a4 = a; op_b4 = b; bin4 = bin; in_valid4 = 1'b1;
          sent++;
        end
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b0;
      check("rand_all_results", 128'(got), 128'(1000));
      check("rand_queue_empty", 128'(sb.size()), 128'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
